// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: states, instruction
// classes, opcodes, control-bundle bit positions and ALU i-op codes.
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  // Determines the path after EXEC.
  typedef enum logic [1:0] {
    CLS_BRANCH = 2'd0,  // jumps and branches finish in EXEC
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_ALU    = 2'd3   // R-type, ALU immediates, LUI
  } instr_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam int CB_REG_DEST   = 0;
  localparam int CB_JUMP       = 1;
  localparam int CB_BEQ        = 2;
  localparam int CB_BNE        = 3;
  localparam int CB_MEM_WRITE  = 4;
  localparam int CB_MEM_READ   = 5;
  localparam int CB_ALU_OP0    = 6;
  localparam int CB_ALU_OP1    = 7;
  localparam int CB_MEM_TO_REG = 8;
  localparam int CB_WRITE_REG  = 9;
  localparam int CB_ALU_SRC    = 10;
  localparam int CB_LUI        = 11;

  localparam logic [3:0] IOP_AND = 4'd0;
  localparam logic [3:0] IOP_OR  = 4'd1;
  localparam logic [3:0] IOP_ADD = 4'd2;
  localparam logic [3:0] IOP_SLT = 4'd7;

  // States in which the memory interface is being waited on.
  function automatic logic is_mem_phase(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_ctrl_decode_rom.sv
// Combinational opcode decoder: control bundle, ALU i-op, instruction class
// and illegal-opcode flag. Registered by the FSM at the end of DECODE.
module multicycle_control_fsm_ctrl_decode_rom
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int CTRL_W   = 12,
  parameter int IOP_W    = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [IOP_W-1:0]    iop,
  output instr_cls_t          cls,
  output logic                illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl    = '0;
    iop     = '0;
    cls     = CLS_ALU;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl[CB_REG_DEST]  = 1'b1;
        ctrl[CB_ALU_OP1]   = 1'b1;
        ctrl[CB_WRITE_REG] = 1'b1;
      end
      OP_LW: begin
        ctrl[CB_MEM_READ]   = 1'b1;
        ctrl[CB_MEM_TO_REG] = 1'b1;
        ctrl[CB_WRITE_REG]  = 1'b1;
        ctrl[CB_ALU_SRC]    = 1'b1;
        cls                 = CLS_LOAD;
      end
      OP_SW: begin
        ctrl[CB_MEM_WRITE] = 1'b1;
        ctrl[CB_ALU_SRC]   = 1'b1;
        cls                = CLS_STORE;
      end
      OP_BEQ, OP_BNE: begin
        ctrl[CB_BEQ]     = (opcode == OP_BEQ);
        ctrl[CB_BNE]     = (opcode == OP_BNE);
        ctrl[CB_ALU_OP1] = 1'b1;
        cls              = CLS_BRANCH;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
        ctrl[CB_ALU_OP0]   = 1'b1;
        ctrl[CB_ALU_OP1]   = 1'b1;
        ctrl[CB_WRITE_REG] = 1'b1;
        ctrl[CB_ALU_SRC]   = 1'b1;
        case (opcode)
          OP_ADDI, OP_ADDIU: iop = IOP_ADD;
          OP_SLTI, OP_SLTIU: iop = IOP_SLT;
          OP_ORI:            iop = IOP_OR;
          default:           iop = IOP_AND;
        endcase
      end
      OP_LUI: begin
        ctrl[CB_WRITE_REG] = 1'b1;
        ctrl[CB_ALU_SRC]   = 1'b1;
        ctrl[CB_LUI]       = 1'b1;
      end
      OP_J, OP_JAL: begin
        ctrl[CB_JUMP] = 1'b1;
        cls           = CLS_BRANCH;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// wait states, stall freeze, illegal-opcode and memory-timeout handling.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int CTRL_W      = 12,
  parameter int IOP_W       = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ack,
  output logic [CTRL_W-1:0]   ctrl_bus,
  output logic [IOP_W-1:0]    i_op,
  output logic                mem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                rf_write,
  output logic                illegal,
  output logic                timeout,
  output logic                busy
);

  localparam int TIMER_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state;
  state_t             state_next;
  state_t             end_state;
  instr_cls_t         cls;
  logic [TIMER_W-1:0] timer;
  logic               mem_phase;
  logic               expired;

  logic [CTRL_W-1:0]  rom_ctrl;
  logic [IOP_W-1:0]   rom_iop;
  instr_cls_t         rom_cls;
  logic               rom_illegal;

  multicycle_control_fsm_ctrl_decode_rom #(
    .OPCODE_W (OPCODE_W),
    .CTRL_W   (CTRL_W),
    .IOP_W    (IOP_W)
  ) u_rom (
    .opcode  (opcode),
    .ctrl    (rom_ctrl),
    .iop     (rom_iop),
    .cls     (rom_cls),
    .illegal (rom_illegal)
  );

  assign mem_phase = is_mem_phase(state);
  assign expired   = mem_phase && !mem_ack && (timer == TIMER_W'(MEM_TIMEOUT - 1));
  // Where a finished instruction goes: next fetch, or park when run has dropped.
  assign end_state = run ? ST_FETCH : ST_IDLE;
  assign mem_req   = mem_phase;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    rf_write   = 1'b0;
    illegal    = 1'b0;
    timeout    = 1'b0;
    // Stall outranks everything, including a pending mem_ack.
    if (!stall) begin
      case (state)
        ST_IDLE: if (run) state_next = ST_FETCH;
        ST_FETCH: begin
          if (mem_ack) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = ST_DECODE;
          end else if (expired) begin
            timeout    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_DECODE: begin
          if (rom_illegal) begin
            illegal    = 1'b1;
            state_next = end_state;
          end else begin
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls)
            CLS_BRANCH: begin
              pc_write   = 1'b1;
              state_next = end_state;
            end
            CLS_LOAD, CLS_STORE: state_next = ST_MEM;
            default:             state_next = ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            state_next = (cls == CLS_LOAD) ? ST_WB : end_state;
          end else if (expired) begin
            timeout    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_WB: begin
          rf_write   = 1'b1;
          state_next = end_state;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      cls      <= CLS_ALU;
      ctrl_bus <= '0;
      i_op     <= '0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (state_next != state) begin
        timer <= '0;
      end else if (mem_phase) begin
        timer <= timer + TIMER_W'(1);
      end
      // Bundle is captured once on DECODE->EXEC and held until the instruction ends.
      if ((state == ST_DECODE) && (state_next == ST_EXEC)) begin
        ctrl_bus <= rom_ctrl;
        i_op     <= rom_iop;
        cls      <= rom_cls;
      end else if ((state_next == ST_IDLE) || (state_next == ST_FETCH) ||
                   (state_next == ST_DECODE)) begin
        ctrl_bus <= '0;
        i_op     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a phase-queue model.
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ack = 1'b0;
  logic [11:0] ctrl_bus;
  logic [3:0]  i_op;
  logic        mem_req, ir_write, pc_write, rf_write, illegal, timeout, busy;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm #(
    .OPCODE_W    (6),
    .CTRL_W      (12),
    .IOP_W       (4),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .stall    (stall),
    .opcode   (opcode),
    .mem_ack  (mem_ack),
    .ctrl_bus (ctrl_bus),
    .i_op     (i_op),
    .mem_req  (mem_req),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .rf_write (rf_write),
    .illegal  (illegal),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Output word layout: {pad, ctrl_bus, i_op, busy, mem_req, ir, pc, rf, illegal, timeout}
  function automatic logic [31:0] dut_word();
    return {9'd0, ctrl_bus, i_op, busy, mem_req, ir_write, pc_write, rf_write, illegal, timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_now(input string name, input logic [11:0] c, input logic [3:0] i,
                            input logic [6:0] f);
    check(name, dut_word(), {9'd0, c, i, f});
  endtask

  // Drive one cycle's inputs just after the edge, then settle before checking.
  task automatic cyc(input logic r, input logic s, input logic a, input logic [5:0] op);
    @(posedge clk);
    #1;
    run = r; stall = s; mem_ack = a; opcode = op;
    #2;
  endtask

  // Decode table written as hand-computed bundle values.
  function automatic bit lookup(input logic [5:0] op, output logic [11:0] c, output logic [3:0] i);
    c = 12'h000; i = 4'd0;
    case (op)
      6'd0:          c = 12'h281;
      6'd35:         c = 12'h720;
      6'd43:         c = 12'h410;
      6'd4:          c = 12'h084;
      6'd5:          c = 12'h088;
      6'd8, 6'd9:    begin c = 12'h6C0; i = 4'd2; end
      6'd10, 6'd11:  begin c = 12'h6C0; i = 4'd7; end
      6'd12:         begin c = 12'h6C0; i = 4'd0; end
      6'd13:         begin c = 12'h6C0; i = 4'd1; end
      6'd15:         c = 12'hE00;
      6'd2, 6'd3:    c = 12'h002;
      default:       return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // ---------------- behavioural model: queue of remaining phases ----------------
  typedef enum int {PH_F, PH_D, PH_E, PH_M, PH_W} phase_t;
  phase_t     ph_q[$];
  bit         m_busy = 1'b0;
  int         m_wait = 0;
  logic [5:0] m_op = 6'd0;

  task automatic model_start();
    ph_q.delete();
    ph_q.push_back(PH_F);
    ph_q.push_back(PH_D);
    m_busy = 1'b1;
    m_wait = 0;
  endtask

  task automatic model_abort();
    ph_q.delete();
    m_busy = 1'b0;
    m_wait = 0;
  endtask

  task automatic model_pop();
    void'(ph_q.pop_front());
    m_wait = 0;
    if (ph_q.size() == 0) begin
      if (run) model_start();
      else     m_busy = 1'b0;
    end
  endtask

  always @(negedge clk) begin : compare
    logic [11:0] ec, tc;
    logic [3:0]  ei, ti;
    logic [6:0]  ef;
    phase_t      ph;
    bit          jmp;
    if (rst) begin
      model_abort();
    end else begin
      ec = 12'h000; ei = 4'd0; ef = 7'd0; ph = PH_F;
      jmp = (m_op == 6'd2) || (m_op == 6'd3) || (m_op == 6'd4) || (m_op == 6'd5);
      if (m_busy) begin
        ph = ph_q[0];
        ef[6] = 1'b1;
        if (ph == PH_F || ph == PH_M) ef[5] = 1'b1;
        if (ph == PH_E || ph == PH_M || ph == PH_W) void'(lookup(m_op, ec, ei));
        if (!stall) begin
          case (ph)
            PH_F: if (mem_ack) ef[4:3] = 2'b11;
                  else if (m_wait == MEM_TIMEOUT - 1) ef[0] = 1'b1;
            PH_D: if (!lookup(opcode, tc, ti)) ef[1] = 1'b1;
            PH_E: if (jmp) ef[3] = 1'b1;
            PH_M: if (!mem_ack && m_wait == MEM_TIMEOUT - 1) ef[0] = 1'b1;
            PH_W: ef[2] = 1'b1;
            default: ;
          endcase
        end
      end
      check("cycle", dut_word(), {9'd0, ec, ei, ef});
      if (!stall) begin
        if (!m_busy) begin
          if (run) model_start();
        end else begin
          case (ph)
            PH_F, PH_M: begin
              if (mem_ack) model_pop();
              else if (m_wait == MEM_TIMEOUT - 1) model_abort();
              else m_wait++;
            end
            PH_D: begin
              m_op = opcode;
              if (lookup(opcode, tc, ti)) begin
                ph_q.push_back(PH_E);
                if (opcode == 6'd35) begin ph_q.push_back(PH_M); ph_q.push_back(PH_W); end
                else if (opcode == 6'd43) ph_q.push_back(PH_M);
                else if (!(opcode inside {6'd2, 6'd3, 6'd4, 6'd5})) ph_q.push_back(PH_W);
              end
              model_pop();
            end
            default: model_pop();
          endcase
        end
      end
    end
  end

  logic [5:0] op_pool [14] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd9,
                               6'd10, 6'd11, 6'd12, 6'd13, 6'd15, 6'd2, 6'd3};
  int ack_pct [3] = '{5, 50, 90};

  initial begin
    #3;
    expect_now("reset_t0", 12'h000, 4'd0, 7'b0000000);
    cyc(1, 0, 1, 6'd0);
    expect_now("reset_held", 12'h000, 4'd0, 7'b0000000);
    @(posedge clk); #1; rst = 1'b0; run = 1'b0;

    // R-type, ack tied high
    cyc(1, 0, 1, 6'd0);  expect_now("r_idle",   12'h000, 4'd0, 7'b0000000);
    cyc(1, 0, 1, 6'd0);  expect_now("r_fetch",  12'h000, 4'd0, 7'b1111000);
    cyc(1, 0, 1, 6'd0);  expect_now("r_decode", 12'h000, 4'd0, 7'b1000000);
    cyc(1, 0, 1, 6'd0);  expect_now("r_exec",   12'h281, 4'd0, 7'b1000000);
    cyc(0, 0, 1, 6'd0);  expect_now("r_wb",     12'h281, 4'd0, 7'b1000100);
    cyc(0, 0, 1, 6'd0);  expect_now("r_done",   12'h000, 4'd0, 7'b0000000);

    // LW with three wait cycles in MEM
    cyc(1, 0, 1, 6'd35); expect_now("lw_idle",   12'h000, 4'd0, 7'b0000000);
    cyc(1, 0, 1, 6'd35); expect_now("lw_fetch",  12'h000, 4'd0, 7'b1111000);
    cyc(1, 0, 0, 6'd35); expect_now("lw_decode", 12'h000, 4'd0, 7'b1000000);
    cyc(1, 0, 0, 6'd35); expect_now("lw_exec",   12'h720, 4'd0, 7'b1000000);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 6'd35); expect_now("lw_mem_wait", 12'h720, 4'd0, 7'b1100000);
    end
    cyc(1, 0, 1, 6'd35); expect_now("lw_mem_ack", 12'h720, 4'd0, 7'b1100000);
    cyc(0, 0, 0, 6'd35); expect_now("lw_wb",      12'h720, 4'd0, 7'b1000100);
    cyc(0, 0, 0, 6'd35); expect_now("lw_done",    12'h000, 4'd0, 7'b0000000);

    // Illegal opcode, then a fetch that never gets acked
    cyc(1, 0, 1, 6'd63); expect_now("ill_idle",   12'h000, 4'd0, 7'b0000000);
    cyc(1, 0, 1, 6'd63); expect_now("ill_fetch",  12'h000, 4'd0, 7'b1111000);
    cyc(1, 0, 0, 6'd63); expect_now("ill_decode", 12'h000, 4'd0, 7'b1000010);
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      cyc(0, 0, 0, 6'd63);
      if (k < MEM_TIMEOUT) expect_now("to_wait",  12'h000, 4'd0, 7'b1100000);
      else                 expect_now("to_pulse", 12'h000, 4'd0, 7'b1100001);
    end
    cyc(0, 0, 0, 6'd0);  expect_now("to_idle", 12'h000, 4'd0, 7'b0000000);

    // ORI with a two-cycle stall in WB
    cyc(1, 0, 1, 6'd13); expect_now("ori_idle",   12'h000, 4'd0, 7'b0000000);
    cyc(1, 0, 1, 6'd13); expect_now("ori_fetch",  12'h000, 4'd0, 7'b1111000);
    cyc(1, 0, 0, 6'd13); expect_now("ori_decode", 12'h000, 4'd0, 7'b1000000);
    cyc(1, 0, 0, 6'd13); expect_now("ori_exec",   12'h6C0, 4'd1, 7'b1000000);
    cyc(1, 1, 0, 6'd13); expect_now("ori_wb_st1", 12'h6C0, 4'd1, 7'b1000000);
    cyc(1, 1, 0, 6'd13); expect_now("ori_wb_st2", 12'h6C0, 4'd1, 7'b1000000);
    cyc(0, 0, 0, 6'd13); expect_now("ori_wb",     12'h6C0, 4'd1, 7'b1000100);
    cyc(0, 0, 0, 6'd13); expect_now("ori_done",   12'h000, 4'd0, 7'b0000000);

    // Stall over an acked fetch, then J
    cyc(1, 0, 1, 6'd2);  expect_now("j_idle",     12'h000, 4'd0, 7'b0000000);
    cyc(1, 1, 1, 6'd2);  expect_now("j_fetch_st", 12'h000, 4'd0, 7'b1100000);
    cyc(1, 0, 1, 6'd2);  expect_now("j_fetch",    12'h000, 4'd0, 7'b1111000);
    cyc(1, 0, 0, 6'd2);  expect_now("j_decode",   12'h000, 4'd0, 7'b1000000);
    cyc(0, 0, 0, 6'd2);  expect_now("j_exec",     12'h002, 4'd0, 7'b1001000);
    cyc(0, 0, 0, 6'd2);  expect_now("j_done",     12'h000, 4'd0, 7'b0000000);

    // Async reset in the middle of an R-type EXEC
    cyc(1, 0, 1, 6'd0);
    cyc(1, 0, 1, 6'd0);
    cyc(1, 0, 0, 6'd0);
    cyc(1, 0, 0, 6'd0);  expect_now("rst_exec", 12'h281, 4'd0, 7'b1000000);
    rst = 1'b1; #1;
    expect_now("rst_async", 12'h000, 4'd0, 7'b0000000);
    cyc(0, 0, 0, 6'd0);
    @(posedge clk); #1; rst = 1'b0;
    cyc(0, 0, 0, 6'd0);  expect_now("rst_after1", 12'h000, 4'd0, 7'b0000000);
    cyc(0, 0, 0, 6'd0);  expect_now("rst_after2", 12'h000, 4'd0, 7'b0000000);

    // Randomized traffic; the compare process checks every cycle
    for (int seg = 0; seg < 15; seg++) begin
      int ap;
      ap = ack_pct[$urandom_range(0, 2)];
      for (int n = 0; n < 200; n++) begin
        logic [5:0] op;
        if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
        else                           op = op_pool[$urandom_range(0, 13)];
        cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 99) < ap), op);
      end
    end

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
